// File: rtl/vga_sync_decoder.sv
//==============================================================================
// Module   : vga_sync_decoder
// Brief    : Rebuilds position counters from HSYNC/VSYNC strobes, measures the
//            incoming timing and runs a lock FSM on it.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_sync_decoder #(
    parameter int CW          = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          HSYNC_IN,
    input  logic          VSYNC_IN,
    output logic [CW-1:0] HORIZ_C,
    output logic [CW-1:0] VERT_C,
    output logic [CW-1:0] LINE_LEN,
    output logic [CW-1:0] HSYNC_LEN,
    output logic [CW-1:0] FRAME_LINES,
    output logic          NEW_FRAME,
    output logic          LOCKED,
    output logic          TIMING_ERR
);

    localparam int                 c_FCW       = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
    localparam logic [c_FCW-1:0]   c_LOCK_LAST = c_FCW'(LOCK_FRAMES - 1);
    localparam logic [CW-1:0]      c_MAX       = '1;

    localparam logic [1:0] c_ST_SEARCH = 2'd0;
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic             r_hs_q, r_vs_q;
    logic [CW-1:0]    r_horiz, r_vert;
    logic [CW-1:0]    r_line_len, r_hsync_len, r_frame_lines;
    logic             r_new_frame, r_timing_err;
    logic             r_line_valid, r_vs_pend, r_h_ovf, r_v_ovf;
    logic [1:0]       r_state;
    logic [CW-1:0]    r_ref_line, r_ref_frame;
    logic             r_ref_valid;
    logic [c_FCW-1:0] r_frame_cnt;

    logic             w_hs_rise, w_hs_fall, w_vs_rise, w_boundary;
    logic [CW-1:0]    w_h_inc, w_v_inc;
    logic [1:0]       w_state_nxt;
    logic             w_err, w_cap_line, w_cap_frame, w_cnt_inc;

    assign w_hs_rise  = HSYNC_IN & ~r_hs_q;
    assign w_hs_fall  = ~HSYNC_IN & r_hs_q;
    assign w_vs_rise  = VSYNC_IN & ~r_vs_q;
    // A vsync seen earlier in the line, or on this very edge, makes this hsync the frame boundary
    assign w_boundary = w_hs_rise & (r_vs_pend | w_vs_rise);
    assign w_h_inc    = r_horiz + 1'b1;
    assign w_v_inc    = r_vert + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hs_q        <= 1'b0;
            r_vs_q        <= 1'b0;
            r_horiz       <= '0;
            r_vert        <= '0;
            r_line_len    <= '0;
            r_hsync_len   <= '0;
            r_frame_lines <= '0;
            r_new_frame   <= 1'b0;
            r_timing_err  <= 1'b0;
            r_line_valid  <= 1'b0;
            r_vs_pend     <= 1'b0;
            r_h_ovf       <= 1'b0;
            r_v_ovf       <= 1'b0;
        end else begin
            r_hs_q       <= HSYNC_IN;
            r_vs_q       <= VSYNC_IN;
            r_new_frame  <= 1'b0;
            r_timing_err <= w_err;

            if (w_hs_rise) begin
                r_horiz      <= '0;
                r_line_valid <= 1'b1;
                if (r_line_valid) begin
                    r_line_len <= w_h_inc;
                end
            end else if (r_horiz != c_MAX) begin
                r_horiz <= w_h_inc;
                if (w_h_inc == c_MAX) begin
                    r_h_ovf <= 1'b1;
                end
            end

            if (w_hs_fall) begin
                r_hsync_len <= w_h_inc;
            end

            if (w_boundary) begin
                r_vert        <= '0;
                r_frame_lines <= w_v_inc;
                r_new_frame   <= 1'b1;
                r_vs_pend     <= 1'b0;
                r_h_ovf       <= 1'b0;
                r_v_ovf       <= 1'b0;
            end else begin
                if (w_vs_rise) begin
                    r_vs_pend <= 1'b1;
                end
                if (w_hs_rise && (r_vert != c_MAX)) begin
                    r_vert <= w_v_inc;
                    if (w_v_inc == c_MAX) begin
                        r_v_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Line length is checked on every hsync; frame length only once the line check has passed
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_cap_line  = 1'b0;
        w_cap_frame = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            c_ST_SEARCH: begin
                if (w_boundary && r_line_valid) begin
                    w_cap_line  = 1'b1;
                    w_state_nxt = c_ST_VERIFY;
                end
            end
            c_ST_VERIFY, c_ST_LOCKED: begin
                if (w_hs_rise) begin
                    if ((w_h_inc != r_ref_line) || r_h_ovf || r_v_ovf) begin
                        w_err       = 1'b1;
                        w_state_nxt = c_ST_SEARCH;
                    end else if (w_boundary) begin
                        if (!r_ref_valid) begin
                            w_cap_frame = 1'b1;
                        end else if (w_v_inc != r_ref_frame) begin
                            w_err       = 1'b1;
                            w_state_nxt = c_ST_SEARCH;
                        end else if (r_state == c_ST_VERIFY) begin
                            if (r_frame_cnt == c_LOCK_LAST) begin
                                w_state_nxt = c_ST_LOCKED;
                            end else begin
                                w_cnt_inc = 1'b1;
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = c_ST_SEARCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ref_line  <= '0;
            r_ref_frame <= '0;
            r_ref_valid <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_cap_line) begin
                r_ref_line  <= w_h_inc;
                r_ref_valid <= 1'b0;
                r_frame_cnt <= '0;
            end
            if (w_cap_frame) begin
                r_ref_frame <= w_v_inc;
                r_ref_valid <= 1'b1;
            end
            if (w_cnt_inc) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign HORIZ_C     = r_horiz;
    assign VERT_C      = r_vert;
    assign LINE_LEN    = r_line_len;
    assign HSYNC_LEN   = r_hsync_len;
    assign FRAME_LINES = r_frame_lines;
    assign NEW_FRAME   = r_new_frame;
    assign LOCKED      = (r_state == c_ST_LOCKED);
    assign TIMING_ERR  = r_timing_err;

endmodule

`default_nettype wire

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive side of the VGA sync interface. Takes active-high HSYNC/VSYNC strobes, of the kind the display timing generator drives, and rebuilds the horizontal and vertical position counters from them.
- Measures line length, hsync width and lines per frame.
- Runs a lock FSM that declares the incoming timing stable.
- Used for loopback self-test of the video timing path and for capture logic that must follow an external sync source.

Parameters:
- CW, 10, width of every counter and measurement output.
- LOCK_FRAMES, 2, number of consecutive matching frames required after the reference capture before LOCKED asserts (≥1).

Ports:
- CLK  input  1  pixel clock; single clock domain.
- RST  input  1  synchronous active-high reset.
- HSYNC_IN  input  1  horizontal sync, 1 = in sync, synchronous to CLK.
- VSYNC_IN  input  1  vertical sync, 1 = in sync, synchronous to CLK.
- HORIZ_C  output  CW  recovered horizontal position; 0 on the first cycle after the hsync rising edge.
- VERT_C  output  CW  recovered line number; 0 on the first line after the frame boundary.
- LINE_LEN  output  CW  cycles between the last two hsync rising edges.
- HSYNC_LEN  output  CW  cycles hsync was high in the last completed pulse.
- FRAME_LINES  output  CW  lines in the last completed frame.
- NEW_FRAME  output  1  one-cycle pulse at each frame boundary.
- LOCKED  output  1  timing stable.
- TIMING_ERR  output  1  one-cycle pulse when lock is lost or verify fails.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: all outputs are 0; FSM state is SEARCH; internal hs_q/vs_q, line_valid, vs_pend, ref_valid and frame_cnt are all 0. RST asserted mid-frame aborts everything on the next edge.
- Edge detect: hs_q <= HSYNC_IN each cycle.
  - hs_rise = HSYNC_IN & ~hs_q; hs_fall = ~HSYNC_IN & hs_q.
  - vs_rise is formed the same way from VSYNC_IN.
- Horizontal counter:
  - On hs_rise: HORIZ_C <= 0, LINE_LEN <= HORIZ_C+1 (only if line_valid, else LINE_LEN is unchanged), line_valid <= 1.
  - Otherwise HORIZ_C increments and saturates at 2^CW-1; reaching saturation sets the internal flag h_ovf.
  - On hs_fall: HSYNC_LEN <= HORIZ_C+1.
  - Latency: HORIZ_C = 0 appears one cycle after HSYNC_IN first samples high.
- Vertical counter:
  - vs_rise sets vs_pend.
  - On hs_rise with (vs_pend | vs_rise): frame boundary. VERT_C <= 0, FRAME_LINES <= VERT_C+1, NEW_FRAME = 1 for one cycle, vs_pend <= 0.
  - On hs_rise without a pending vsync: VERT_C increments and saturates; saturation sets v_ovf.
  - vs_rise without a following hsync leaves vs_pend set indefinitely.
  - Both h_ovf and v_ovf clear at the next frame boundary.
- Lock FSM:
  - SEARCH: LOCKED = 0. On a frame boundary with line_valid = 1: ref_line <= the LINE_LEN value being written, ref_valid <= 0, frame_cnt <= 0, go to VERIFY.
  - VERIFY, on every hs_rise:
    - If the new line length ≠ ref_line, or h_ovf/v_ovf is set: TIMING_ERR pulse, go to SEARCH.
    - A frame-boundary hs_rise is checked against ref_line first; the frame handling below applies only if that check passes.
  - VERIFY, on a frame boundary:
    - If !ref_valid: ref_frame <= new FRAME_LINES, ref_valid <= 1.
    - Else if FRAME_LINES ≠ ref_frame: TIMING_ERR pulse, go to SEARCH.
    - Else frame_cnt++; when frame_cnt+1 == LOCK_FRAMES, go to LOCKED (LOCKED = 1 from the next cycle).
  - LOCKED: the same line and frame checks as VERIFY. Any mismatch or overflow gives a TIMING_ERR pulse, LOCKED = 0 from the next cycle, and the FSM goes to SEARCH.
  - Going to SEARCH does not itself start a new acquisition. The next frame boundary with line_valid = 1 restarts VERIFY.
- Hsync width: not a lock criterion; reported only.
- Simultaneous events: hs_rise and vs_rise in the same cycle is a frame boundary on that edge. hs_rise and hs_fall are mutually exclusive.

Test Plan:
- Reset then 640x480 stream (800-cycle lines, 96-cycle hsync, 525 lines, 2-line vsync), LOCK_FRAMES = 2:
  - LINE_LEN = 800, HSYNC_LEN = 96, FRAME_LINES = 525.
  - VERIFY entered at boundary 1, ref_frame captured at boundary 2.
  - LOCKED = 1 one cycle after boundary 4; NEW_FRAME pulses once per boundary; TIMING_ERR never asserts.
- Position counters: HORIZ_C = 0 on the cycle after HSYNC_IN rises and HORIZ_C = 799 on the cycle before the next rise. VERT_C = 0 on the first line of a frame and VERT_C = 524 on the last.
- While LOCKED, inject one 801-cycle line: TIMING_ERR pulses on that hs_rise, LOCKED = 0 on the next cycle, FSM in SEARCH. Relocks after 4 further clean boundaries.
- While LOCKED, drop one line (524-line frame): TIMING_ERR at that boundary and LOCKED deasserts.
- Hold HSYNC_IN = 0 for 1100 cycles: HORIZ_C saturates at 1023, and at the next hs_rise TIMING_ERR pulses. Repeat with VSYNC_IN rising in the same cycle as HSYNC_IN: one NEW_FRAME and VERT_C = 0.
- Assert RST for one cycle mid-frame while LOCKED: all outputs 0 on the next cycle. Lock is reacquired only after 4 boundaries, the first of which follows a complete line.
